// File: rtl/stat_report_pkg.sv
// Shared definitions for stat_reporter: ASCII constants, hex digit encoding,
// frame length arithmetic and the FSM state type.
package stat_report_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic int frame_len(input int num_ch, input int cnt_d,
                                   input int seq_d, input bit csum_en);
    return seq_d + num_ch * (3 + cnt_d) + 2 + (csum_en ? 4 : 0);
  endfunction

endpackage

// File: rtl/stat_reporter_if.sv
// Byte stream from stat_reporter to the UART transmitter.
interface stat_reporter_if;
  logic [7:0] data;
  logic       valid;
  logic       require;

  modport master (output data, output valid, input require);
  modport slave  (input data, input valid, output require);
endinterface

// File: rtl/report_timer.sv
// Free-running period counter; tick is high during the last count so the
// request is sampled on the same edge that wraps the counter.
module report_timer #(
  parameter int REPORT_COUNT = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int TW = (REPORT_COUNT > 1) ? $clog2(REPORT_COUNT) : 1;

  logic [TW-1:0] count_reg;
  logic          wrap;

  assign wrap = (count_reg == TW'(REPORT_COUNT - 1));
  assign tick = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count_reg <= '0;
    else if (wrap) count_reg <= '0;
    else           count_reg <= count_reg + 1'b1;
  end
endmodule

// File: rtl/stat_reporter.sv
// Snapshots NUM_CH counters and a sequence number into an uppercase-hex text line
// and streams it byte by byte. Define REPORT_CHECKSUM_EN to append " *XX" before CR LF.
module stat_reporter
  import stat_report_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int REPORT_FREQ = 2,
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int SEQ_WIDTH   = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*CNT_WIDTH-1:0] counters,
  input  logic                        trigger,
  stat_reporter_if.master             tx,
  output logic                        busy,
  output logic [7:0]                  drop_cnt
);
  localparam int REPORT_COUNT = CLK_FREQ / REPORT_FREQ;
  localparam int CNT_D        = CNT_WIDTH / 4;
  localparam int SEQ_D        = SEQ_WIDTH / 4;
  localparam int CH_LEN       = 3 + CNT_D;
  localparam int BODY_END     = SEQ_D + NUM_CH * CH_LEN;
`ifdef REPORT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(NUM_CH, CNT_D, SEQ_D, CSUM_EN);
  localparam int IW        = $clog2(FRAME_LEN);
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW        = $clog2(CH_LEN);

  localparam logic [IW-1:0] IDX_SEQ_END   = IW'(SEQ_D);
  localparam logic [IW-1:0] IDX_SEQ_LAST  = IW'(SEQ_D - 1);
  localparam logic [IW-1:0] IDX_BODY_END  = IW'(BODY_END);
  localparam logic [IW-1:0] IDX_BODY_LAST = IW'(BODY_END - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_LAST      = PW'(CH_LEN - 1);

  state_t                      state_reg, state_next;
  logic [IW-1:0]               idx_reg, idx_next;
  logic [CW-1:0]               ch_reg, ch_next;
  logic [PW-1:0]               pos_reg, pos_next;
  logic [SEQ_WIDTH-1:0]        seq_reg, seq_next;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_reg, snap_next;
  logic [7:0]                  drop_reg, drop_next;
  logic                        valid_reg, valid_next;
  logic [7:0]                  data_reg;
`ifdef REPORT_CHECKSUM_EN
  logic [7:0]                  csum_reg, csum_next;
`endif

  logic                 tick, request, accept;
  logic [7:0]           byte_sel;
  logic [3:0]           nib_sel;
  logic [IW-1:0]        tail_pos;
  logic [CNT_WIDTH-1:0] cnt_sel;

  report_timer #(.REPORT_COUNT(REPORT_COUNT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign request = tick | trigger;
  assign accept  = valid_reg & tx.require;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ch_next    = ch_reg;
    pos_next   = pos_reg;
    seq_next   = seq_reg;
    snap_next  = snap_reg;
    drop_next  = drop_reg;
    valid_next = valid_reg;
`ifdef REPORT_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (request) begin
          state_next = ST_SEND;
          idx_next   = '0;
          ch_next    = '0;
          pos_next   = '0;
          seq_next   = seq_reg + 1'b1;
          snap_next  = counters;
          valid_next = 1'b1;
`ifdef REPORT_CHECKSUM_EN
          csum_next  = 8'h00;
`endif
        end
      end
      ST_SEND: begin
        if (request && drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
        if (accept) begin
`ifdef REPORT_CHECKSUM_EN
          if (idx_reg <= IDX_BODY_LAST) csum_next = csum_reg ^ data_reg;
`endif
          if (idx_reg == IDX_LAST) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
          end else begin
            idx_next = idx_reg + 1'b1;
            // channel/position track the body; they stay parked on the last body byte
            if (idx_reg >= IDX_SEQ_END && idx_reg < IDX_BODY_LAST) begin
              if (pos_reg == POS_LAST) begin
                pos_next = '0;
                ch_next  = ch_reg + 1'b1;
              end else begin
                pos_next = pos_reg + 1'b1;
              end
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Decode the byte for the post-edge index so data can be registered.
  always_comb begin
    byte_sel = CH_LF;
    nib_sel  = 4'h0;
    tail_pos = idx_next - IDX_BODY_END;
    cnt_sel  = snap_next[ch_next*CNT_WIDTH +: CNT_WIDTH];
    if (idx_next < IDX_SEQ_END) begin
      nib_sel  = 4'(seq_next >> (4 * (IDX_SEQ_LAST - idx_next)));
      byte_sel = hex_ascii(nib_sel);
    end else if (idx_next < IDX_BODY_END) begin
      if (pos_next == PW'(0))      byte_sel = CH_SPACE;
      else if (pos_next == PW'(1)) byte_sel = hex_ascii(4'(ch_next));
      else if (pos_next == PW'(2)) byte_sel = CH_COLON;
      else begin
        nib_sel  = 4'(cnt_sel >> (4 * (POS_LAST - pos_next)));
        byte_sel = hex_ascii(nib_sel);
      end
    end else begin
`ifdef REPORT_CHECKSUM_EN
      if (tail_pos == IW'(0))      byte_sel = CH_SPACE;
      else if (tail_pos == IW'(1)) byte_sel = CH_STAR;
      else if (tail_pos == IW'(2)) byte_sel = hex_ascii(csum_next[7:4]);
      else if (tail_pos == IW'(3)) byte_sel = hex_ascii(csum_next[3:0]);
      else if (tail_pos == IW'(4)) byte_sel = CH_CR;
      else                         byte_sel = CH_LF;
`else
      byte_sel = (tail_pos == IW'(0)) ? CH_CR : CH_LF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      ch_reg    <= '0;
      pos_reg   <= '0;
      seq_reg   <= '0;
      snap_reg  <= '0;
      drop_reg  <= 8'h00;
      valid_reg <= 1'b0;
      data_reg  <= 8'h00;
`ifdef REPORT_CHECKSUM_EN
      csum_reg  <= 8'h00;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ch_reg    <= ch_next;
      pos_reg   <= pos_next;
      seq_reg   <= seq_next;
      snap_reg  <= snap_next;
      drop_reg  <= drop_next;
      valid_reg <= valid_next;
      data_reg  <= valid_next ? byte_sel : 8'h00;
`ifdef REPORT_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  assign tx.data  = data_reg;
  assign tx.valid = valid_reg;
  assign busy     = (state_reg == ST_SEND);
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_stat_reporter.sv
// Directed bench for stat_reporter: instance A (2x16-bit, 8-bit seq, trigger driven)
// and instance B (1x8-bit, 4-bit seq, 100-cycle period) checked against a byte scoreboard.
module tb_stat_reporter;

`ifdef REPORT_CHECKSUM_EN
  localparam int CS_EXTRA = 4;
`else
  localparam int CS_EXTRA = 0;
`endif
  localparam int LA = 2 + 2 * (3 + 4) + 2 + CS_EXTRA;
  localparam int LB = 1 + 1 * (3 + 2) + 2 + CS_EXTRA;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic [31:0] counters_a;
  logic [7:0]  counters_b;
  logic        trigger_a, trigger_b;
  logic        busy_a, busy_b;
  logic [7:0]  drop_a, drop_b;
  int          cyc_b;

  stat_reporter_if if_a ();
  stat_reporter_if if_b ();

  always #5 clk = ~clk;

  stat_reporter #(
    .CLK_FREQ(1_000_000), .REPORT_FREQ(1), .NUM_CH(2), .CNT_WIDTH(16), .SEQ_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .counters(counters_a), .trigger(trigger_a),
    .tx(if_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  stat_reporter #(
    .CLK_FREQ(100), .REPORT_FREQ(1), .NUM_CH(1), .CNT_WIDTH(8), .SEQ_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .counters(counters_b), .trigger(trigger_b),
    .tx(if_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  always @(posedge clk) begin
    if (!rst_n_b) cyc_b <= 0;
    else          cyc_b <= cyc_b + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_hex(input logic [3:0] n);
    string h;
    h = "0123456789ABCDEF";
    return h[int'(n)];
  endfunction

  task automatic push_frame(input bit to_b, input logic [15:0] seq, input int seq_d,
                            input logic [31:0] vals, input int nch, input int cnt_d);
    logic [7:0]  q[$];
    logic [31:0] v;
    for (int i = seq_d - 1; i >= 0; i--) q.push_back(tb_hex(seq[i*4 +: 4]));
    for (int c = 0; c < nch; c++) begin
      v = vals >> (c * cnt_d * 4);
      q.push_back(8'h20);
      q.push_back(tb_hex(4'(c)));
      q.push_back(8'h3A);
      for (int d = cnt_d - 1; d >= 0; d--) q.push_back(tb_hex(v[d*4 +: 4]));
    end
`ifdef REPORT_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (q[k]) x ^= q[k];
      q.push_back(8'h20);
      q.push_back(8'h2A);
      q.push_back(tb_hex(x[7:4]));
      q.push_back(tb_hex(x[3:0]));
    end
`endif
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    foreach (q[k]) begin
      if (to_b) exp_b.push_back(q[k]);
      else      exp_a.push_back(q[k]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_b(input int n);
    while (cyc_b < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitors: one line per accepted byte
  logic [7:0] prev_data_a, prev_data_b;
  bit         prev_stall_a = 1'b0, prev_stall_b = 1'b0, prev_valid_b = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n_a) begin
      if (if_a.valid) begin
        if (prev_stall_a) chk("hold_a", 32'(if_a.data), 32'(prev_data_a));
        if (if_a.require) begin
          if (exp_a.size() == 0) chk("sb_underflow_a", 32'(exp_a.size()), 32'd1);
          else begin
            e = exp_a.pop_front();
            chk("byte_a", 32'(if_a.data), 32'(e));
            $display("A byte %02h expected %02h", if_a.data, e);
          end
        end
      end
      prev_stall_a = if_a.valid && !if_a.require;
      prev_data_a  = if_a.data;
    end else begin
      prev_stall_a = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n_b) begin
      if (if_b.valid && !prev_valid_b) chk("phase_b", 32'(cyc_b % 100), 32'd0);
      if (if_b.valid) begin
        if (prev_stall_b) chk("hold_b", 32'(if_b.data), 32'(prev_data_b));
        if (if_b.require) begin
          if (exp_b.size() == 0) chk("sb_underflow_b", 32'(exp_b.size()), 32'd1);
          else begin
            e = exp_b.pop_front();
            chk("byte_b", 32'(if_b.data), 32'(e));
            $display("B byte %02h expected %02h at cycle %0d", if_b.data, e, cyc_b);
          end
        end
      end
      prev_stall_b = if_b.valid && !if_b.require;
      prev_data_b  = if_b.data;
      prev_valid_b = if_b.valid;
    end else begin
      prev_stall_b = 1'b0;
      prev_valid_b = 1'b0;
    end
  end

  initial begin
    rst_n_a      = 1'b0;
    rst_n_b      = 1'b0;
    trigger_a    = 1'b0;
    trigger_b    = 1'b0;
    counters_a   = 32'h0;
    counters_b   = 8'h5C;
    if_a.require = 1'b1;
    if_b.require = 1'b1;
    step(3);

    chk("rst_data_a",  32'(if_a.data), 32'h00);
    chk("rst_valid_a", 32'(if_a.valid), 32'd0);
    chk("rst_busy_a",  32'(busy_a), 32'd0);
    chk("rst_drop_a",  32'(drop_a), 32'd0);
    chk("rst_valid_b", 32'(if_b.valid), 32'd0);

    // basic frame: "01 0:12AB 1:00F0\r\n" on consecutive cycles
    rst_n_a = 1'b1;
    step(2);
    counters_a = {16'h00F0, 16'h12AB};
    push_frame(1'b0, 16'd1, 2, counters_a, 2, 4);
    trigger_a = 1'b1;
    step(1);
    trigger_a = 1'b0;
    for (int i = 0; i < LA; i++) begin
      chk("run_valid_a", 32'(if_a.valid), 32'd1);
      chk("run_busy_a",  32'(busy_a), 32'd1);
      step(1);
    end
    chk("end_busy_a",  32'(busy_a), 32'd0);
    chk("end_valid_a", 32'(if_a.valid), 32'd0);
    chk("sb_empty_a1", 32'(exp_a.size()), 32'd0);

    // backpressure 1,0,0 pattern; counters change mid-frame
    counters_a = {16'hBEEF, 16'h0007};
    push_frame(1'b0, 16'd2, 2, counters_a, 2, 4);
    trigger_a = 1'b1;
    step(1);
    trigger_a = 1'b0;
    for (int k = 0; k < 300 && busy_a; k++) begin
      if_a.require = (k % 3 == 0);
      if (k == 5) counters_a = 32'hFFFF_FFFF;
      step(1);
    end
    if_a.require = 1'b1;
    chk("bp_done_a",   32'(busy_a), 32'd0);
    chk("sb_empty_a2", 32'(exp_a.size()), 32'd0);

    // reset mid-frame at byte 5, with one drop recorded first
    counters_a = {16'h3C3C, 16'hA5A5};
    push_frame(1'b0, 16'd3, 2, counters_a, 2, 4);
    trigger_a = 1'b1;
    step(1);
    trigger_a = 1'b0;
    step(2);
    trigger_a = 1'b1;
    step(1);
    trigger_a = 1'b0;
    step(2);
    chk("pre_rst_drop_a", 32'(drop_a), 32'd1);
    rst_n_a = 1'b0;
    #1;
    chk("mid_rst_valid_a", 32'(if_a.valid), 32'd0);
    chk("mid_rst_data_a",  32'(if_a.data), 32'h00);
    chk("mid_rst_busy_a",  32'(busy_a), 32'd0);
    chk("mid_rst_drop_a",  32'(drop_a), 32'd0);
    chk("abandon_left_a",  32'(exp_a.size()), 32'(LA - 5));
    exp_a.delete();
    step(2);
    rst_n_a = 1'b1;
    step(2);
    push_frame(1'b0, 16'd1, 2, counters_a, 2, 4);
    trigger_a = 1'b1;
    step(1);
    trigger_a = 1'b0;
    for (int k = 0; k < 100 && busy_a; k++) step(1);
    chk("post_rst_done_a", 32'(busy_a), 32'd0);
    chk("sb_empty_a3",     32'(exp_a.size()), 32'd0);

    // periodic instance: ticks at cycles 100, 200, ...
    rst_n_b = 1'b1;
    for (int s = 1; s <= 3; s++) push_frame(1'b1, 16'(s), 1, {24'h0, 8'h5C}, 1, 2);
    go_b(350);
    chk("drop0_b",     32'(drop_b), 32'd0);
    chk("sb_empty_b1", 32'(exp_b.size()), 32'd0);

    // frame 4 stalled across tick 500; three triggers (last coincident with the tick)
    push_frame(1'b1, 16'd4, 1, {24'h0, 8'h5C}, 1, 2);
    go_b(400);
    if_b.require = 1'b0;
    counters_b   = 8'hA7;
    chk("stall_busy_b", 32'(busy_b), 32'd1);
    go_b(409);
    trigger_b = 1'b1;
    step(1);
    trigger_b = 1'b0;
    go_b(419);
    trigger_b = 1'b1;
    step(1);
    trigger_b = 1'b0;
    go_b(499);
    trigger_b = 1'b1;
    step(1);
    trigger_b = 1'b0;
    go_b(505);
    if_b.require = 1'b1;
    go_b(530);
    chk("drop3_b",     32'(drop_b), 32'd3);
    chk("idle_b",      32'(busy_b), 32'd0);
    chk("sb_empty_b2", 32'(exp_b.size()), 32'd0);

    // seq 5..15 then wraps through 0 and 1
    for (int s = 5; s <= 17; s++) push_frame(1'b1, 16'(s % 16), 1, {24'h0, 8'hA7}, 1, 2);
    go_b(1830);
    chk("sb_empty_b3", 32'(exp_b.size()), 32'd0);
    chk("drop_hold_b", 32'(drop_b), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
